// File: rtl/flit_inject_arbiter.sv
// Purpose: wormhole round-robin arbiter sharing one router injection port among N_PORTS flit generators.
// Latency: 1 cycle from accept (write_req_ack) to out_valid; sustains 1 flit/cycle.
// Backpressure: the one-entry output register accepts only when empty or draining; held requests stall.
// Optional build macro INJ_ARB_STATS_EN adds pkt_count and stall_count outputs.
module flit_inject_arbiter #(
    parameter int N_PORTS = 4,
    parameter int FLIT_W  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS*FLIT_W-1:0]   in_flit,
    input  logic [N_PORTS-1:0]          write_req,
    output logic [N_PORTS-1:0]          write_req_ack,
    output logic [FLIT_W-1:0]           out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [$clog2(N_PORTS)-1:0]  owner
`ifdef INJ_ARB_STATS_EN
    ,
    output logic [31:0]                 pkt_count,
    output logic [31:0]                 stall_count
`endif
);

    localparam int PW = $clog2(N_PORTS);

    localparam logic [1:0] T_HEAD = 2'b11;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       r_owner;
    logic                r_busy;
    logic [FLIT_W-1:0]   r_out_flit;
    logic                r_out_valid;

    logic [FLIT_W-1:0]   w_flit [N_PORTS];
    logic [1:0]          w_type [N_PORTS];
    logic [N_PORTS-1:0]  w_eligible;
    logic                w_slot_free;
    logic                w_win_vld;
    logic [PW-1:0]       w_win_idx;
    logic                w_own_ok;
    logic                w_acc_vld;
    logic [PW-1:0]       w_acc_idx;
    logic [N_PORTS-1:0]  w_ack;
    logic [FLIT_W-1:0]   w_acc_flit;
    logic                w_tail_acc;
    logic [PW-1:0]       w_rr_next;

    // Unpack per-port flits and decode their type fields
    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        assign w_flit[g]     = in_flit[g*FLIT_W +: FLIT_W];
        assign w_type[g]     = w_flit[g][FLIT_W-1 -: 2];
        assign w_eligible[g] = write_req[g] & (w_type[g] == T_HEAD);
    end

    assign w_slot_free = !r_out_valid | out_ready;

    // Round-robin search: first head request at or after r_rr_ptr, wrapping
    always_comb begin
        int idx;
        idx       = 0;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!w_win_vld && w_eligible[idx]) begin
                w_win_vld = 1'b1;
                w_win_idx = PW'(idx);
            end
        end
    end

    // While locked only body/tail from the owner may pass; a repeated head is refused
    assign w_own_ok = write_req[r_owner] &
                      ((w_type[r_owner] == T_BODY) || (w_type[r_owner] == T_TAIL));

    // Accept decision; acks are suppressed while reset is asserted
    always_comb begin
        w_acc_vld = 1'b0;
        w_acc_idx = '0;
        w_ack     = '0;
        if (!reset && w_slot_free) begin
            if (r_state == S_IDLE) begin
                if (w_win_vld) begin
                    w_acc_vld = 1'b1;
                    w_acc_idx = w_win_idx;
                end
            end else if (w_own_ok) begin
                w_acc_vld = 1'b1;
                w_acc_idx = r_owner;
            end
        end
        if (w_acc_vld) begin
            w_ack[w_acc_idx] = 1'b1;
        end
    end

    assign w_acc_flit = w_flit[w_acc_idx];
    assign w_tail_acc = w_acc_vld && (r_state == S_LOCKED) && (w_type[r_owner] == T_TAIL);
    assign w_rr_next  = (r_owner == PW'(N_PORTS-1)) ? '0 : r_owner + PW'(1);

    // One-entry output register: load on accept, drain when the router takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_acc_vld) begin
            r_out_flit  <= w_acc_flit;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Packet lock FSM: head locks the port, tail releases it and advances the pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc_vld) begin
                        r_owner <= w_acc_idx;
                        r_state <= S_LOCKED;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_tail_acc) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_rr_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INJ_ARB_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_stall_count;

    // Completed-packet and output-stall counters, both free-running and wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_tail_acc) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (r_out_valid && !out_ready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign pkt_count   = r_pkt_count;
    assign stall_count = r_stall_count;
`endif

    assign write_req_ack = w_ack;
    assign out_flit      = r_out_flit;
    assign out_valid     = r_out_valid;
    assign busy          = r_busy;
    assign owner         = r_owner;

endmodule

// File: tb/tb_flit_inject_arbiter.sv
// Scoreboard bench for flit_inject_arbiter: per-port driver queues, expected output queue, monitor.
// Inputs change 2ns after the rising edge; DUT outputs are sampled on the falling edge.
// Stall phases drop out_ready for several cycles to exercise the output register hold.
module tb_flit_inject_arbiter;

    localparam int N  = 4;
    localparam int FW = 64;

    logic              clk;
    logic              reset;
    logic [N*FW-1:0]   in_flit;
    logic [N-1:0]      write_req;
    logic [N-1:0]      write_req_ack;
    logic [FW-1:0]     out_flit;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [1:0]        owner;
`ifdef INJ_ARB_STATS_EN
    logic [31:0]       pkt_count;
    logic [31:0]       stall_count;
`endif

    flit_inject_arbiter #(.N_PORTS(N), .FLIT_W(FW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_flit       (in_flit),
        .write_req     (write_req),
        .write_req_ack (write_req_ack),
        .out_flit      (out_flit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .owner         (owner)
`ifdef INJ_ARB_STATS_EN
        ,
        .pkt_count     (pkt_count),
        .stall_count   (stall_count)
`endif
    );

    localparam logic [1:0] T_HEAD = 2'b11;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    logic [63:0] port_q [N][$];
    logic [63:0] exp_q [$];
    int          ack_cnt [N];
    int          checks;
    int          failures;
    bit          mon_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] t, input int p, input int seq);
        return {t, 6'd0, 8'(p), 16'hC0DE, 32'(seq)};
    endfunction

    // Queue one packet (head, nbody bodies, tail) on port p; optionally expect it at the output
    task automatic add_pkt(input int p, input int nbody, input int id, input bit to_exp);
        logic [63:0] f;
        logic [1:0]  t;
        for (int k = 0; k < nbody + 2; k++) begin
            t = (k == 0) ? T_HEAD : ((k == nbody + 1) ? T_TAIL : T_BODY);
            f = mk(t, p, id * 16 + k);
            port_q[p].push_back(f);
            if (to_exp) exp_q.push_back(f);
        end
    endtask

    task automatic wait_ack(input int p, input int target, input int budget, input string name);
        int n = 0;
        while (ack_cnt[p] < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(ack_cnt[p] >= target), 64'd1);
    endtask

    task automatic wait_port_empty(input int p, input int budget, input string name);
        int n = 0;
        while (port_q[p].size() > 0 && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        chk(name, 64'(port_q[p].size()), 64'd0);
    endtask

    task automatic wait_exp_empty(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Driver: presents queue heads, pops a flit after the edge at which it was acked
    initial begin
        logic [N-1:0]  ack_snap;
        logic          lat_pend;
        logic [63:0]   lat_flit;
        write_req = '0;
        in_flit   = '0;
        lat_pend  = 1'b0;
        lat_flit  = '0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge clk);
            ack_snap = '0;
            if (!reset) begin
                if (lat_pend) begin
                    chk("latency_valid", 64'(out_valid), 64'd1);
                    chk("latency_flit", out_flit, lat_flit);
                end
                lat_pend = 1'b0;
                chk("ack_onehot0", 64'($onehot0(write_req_ack)), 64'd1);
                chk("ack_without_req", 64'(write_req_ack & ~write_req), 64'd0);
                ack_snap = write_req_ack;
                for (int i = 0; i < N; i++) begin
                    if (ack_snap[i] && port_q[i].size() > 0) begin
                        ack_cnt[i]++;
                        lat_pend = 1'b1;
                        lat_flit = port_q[i][0];
                        if (port_q[i][0][63:62] == T_TAIL) begin
                            chk("busy_at_tail", 64'(busy), 64'd1);
                        end
                    end
                end
            end else begin
                lat_pend = 1'b0;
            end
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (ack_snap[i] && port_q[i].size() > 0) void'(port_q[i].pop_front());
                if (port_q[i].size() > 0) begin
                    write_req[i] = 1'b1;
                    in_flit[i*FW +: FW] = port_q[i][0];
                end else begin
                    write_req[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every transfer must match the next expected flit; stalled output must hold
    initial begin
        logic          prev_stall;
        logic [63:0]   prev_flit;
        logic [63:0]   e;
        prev_stall = 1'b0;
        prev_flit  = '0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_flit", out_flit, prev_flit);
                end
                if (out_valid && !out_ready) begin
                    chk("no_ack_when_full", 64'(write_req_ack), 64'd0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_flit", out_flit, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("order", out_flit, e);
                    end
                end
                prev_stall = out_valid & !out_ready;
                prev_flit  = out_flit;
            end
        end
    end

    // Directed stimulus
    initial begin
        int b;
        checks    = 0;
        failures  = 0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        out_ready = 1'b1;

        // Reset state, with a head already requesting on port 0
        add_pkt(0, 0, 1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_flit", out_flit, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_ack", 64'(write_req_ack), 64'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        wait_port_empty(0, 20, "first_grant_drain");
        @(negedge clk);
        chk("first_grant_owner", 64'(owner), 64'd0);
        wait_exp_empty(20, "first_grant_exp");

        // Single packet on port 2: head, body, body, tail
        b = ack_cnt[2];
        begin
            int others;
            others = ack_cnt[0] + ack_cnt[1] + ack_cnt[3];
            add_pkt(2, 2, 2, 1'b1);
            wait_port_empty(2, 30, "single_drain");
            @(negedge clk);
            chk("single_busy_drop", 64'(busy), 64'd0);
            chk("single_ack_count", 64'(ack_cnt[2] - b), 64'd4);
            chk("single_other_acks", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[3] - others), 64'd0);
            chk("single_owner", 64'(owner), 64'd2);
        end
        wait_exp_empty(20, "single_exp");

        // Reset in the middle of a packet on port 3
        mon_en = 1'b0;
        b = ack_cnt[3];
        port_q[3].push_back(mk(T_HEAD, 3, 999));
        port_q[3].push_back(mk(T_BODY, 3, 1000));
        wait_ack(3, b + 2, 20, "midrst_lock");
        @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        port_q[3].delete();
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ack", 64'(write_req_ack), 64'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        // Pointer is back at 0, so port 1 wins over port 3
        add_pkt(1, 0, 3, 1'b1);
        add_pkt(3, 1, 4, 1'b1);
        wait_exp_empty(60, "post_rst_rr");
        chk("post_rst_owner", 64'(owner), 64'd3);

        // Round robin among ports 0,1,3 with a second packet queued on port 0
        add_pkt(0, 2, 5, 1'b1);
        add_pkt(1, 2, 6, 1'b1);
        add_pkt(3, 2, 7, 1'b1);
        add_pkt(0, 2, 8, 1'b1);
        wait_exp_empty(120, "rr_drain");
        chk("rr_owner", 64'(owner), 64'd0);

        // Backpressure mid-packet for 5 cycles
        b = ack_cnt[2];
        add_pkt(2, 3, 9, 1'b1);
        wait_ack(2, b + 2, 20, "bp_start");
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_no_ack", 64'(ack_cnt[2] - b), 64'd2);
        chk("bp_held_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_exp_empty(40, "bp_drain");

        // Body flit offered while idle is never granted; port 0 head still wins
        b = ack_cnt[1];
        port_q[1].push_back(mk(T_BODY, 1, 77));
        add_pkt(0, 1, 10, 1'b1);
        wait_exp_empty(40, "illegal_drain");
        repeat (4) @(posedge clk);
        #1;
        chk("illegal_no_ack", 64'(ack_cnt[1] - b), 64'd0);
        chk("illegal_pending", 64'(port_q[1].size()), 64'd1);
        chk("illegal_idle", 64'(busy), 64'd0);
        port_q[1].delete();
        repeat (2) @(posedge clk);

`ifdef INJ_ARB_STATS_EN
        // Counters: 3 packets with exactly 2 stall cycles after a fresh reset
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("stats_rst_pkt", 64'(pkt_count), 64'd0);
        chk("stats_rst_stall", 64'(stall_count), 64'd0);
        b = ack_cnt[0];
        add_pkt(0, 1, 11, 1'b1);
        add_pkt(0, 1, 12, 1'b1);
        add_pkt(0, 1, 13, 1'b1);
        wait_ack(0, b + 2, 20, "stats_start");
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_exp_empty(60, "stats_drain");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stats_pkt_count", 64'(pkt_count), 64'd3);
        chk("stats_stall_count", 64'(stall_count), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
